mem_bus_arbiter: RTL and testbench



---
 rtl/mem_arb_pkg.sv | 15 +
 rtl/mem_bus_arbiter_arb_pick.sv | 45 ++++
 rtl/mem_bus_arbiter.sv | 140 ++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared constants and request-encoding helper for the two-master memory bus arbiter.
package mem_arb_pkg;

  localparam logic MASTER_CPU = 1'b0;
  localparam logic MASTER_AUX = 1'b1;

  localparam int BURST_CNT_W = 4;
  localparam logic [BURST_CNT_W-1:0] BURST_CNT_MAX = 4'd15;

  // A master is requesting when it reads, writes any byte, or both.
  function automatic logic req_of(input logic rstrb, input logic [3:0] wmask);
    return rstrb | (|wmask);
  endfunction

endpackage

// File: rtl/mem_bus_arbiter_arb_pick.sv
// Combinational grant decision: single requester wins, contention honours the owner's burst budget.
module arb_pick
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic                   req0,
  input  logic                   req1,
  input  logic                   owner,
  input  logic [BURST_CNT_W-1:0] burst_cnt,
  output logic                   gnt_any,
  output logic                   gnt_sel
);

  localparam logic [BURST_CNT_W-1:0] MAX_BURST_C = MAX_BURST[BURST_CNT_W-1:0];

  // Pick the winning master for this cycle
  always_comb begin
    gnt_any = 1'b0;
    gnt_sel = MASTER_CPU;
    case ({req1, req0})
      2'b01: begin
        gnt_any = 1'b1;
        gnt_sel = MASTER_CPU;
      end
      2'b10: begin
        gnt_any = 1'b1;
        gnt_sel = MASTER_AUX;
      end
      2'b11: begin
        gnt_any = 1'b1;
        if (burst_cnt < MAX_BURST_C) begin
          gnt_sel = owner;
        end else begin
          gnt_sel = ~owner;
        end
      end
      default: begin
        gnt_any = 1'b0;
        gnt_sel = MASTER_CPU;
      end
    endcase
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master round-robin arbiter in front of the single-port 1-cycle-latency RAM.
// Optional grant/conflict statistics counters are built when ARB_STATS_EN is defined.
module mem_bus_arbiter
  import mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] m0_addr,
  input  logic        m0_rstrb,
  input  logic [31:0] m0_wdata,
  input  logic [3:0]  m0_wmask,
  output logic        m0_gnt,
  output logic [31:0] m0_rdata,
  output logic        m0_rvalid,
  input  logic [31:0] m1_addr,
  input  logic        m1_rstrb,
  input  logic [31:0] m1_wdata,
  input  logic [3:0]  m1_wmask,
  output logic        m1_gnt,
  output logic [31:0] m1_rdata,
  output logic        m1_rvalid,
  output logic [31:0] mem_addr,
  output logic        mem_rstrb,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wmask,
  input  logic [31:0] mem_rdata
`ifdef ARB_STATS_EN
  ,
  output logic [31:0] stat_gnt0,
  output logic [31:0] stat_gnt1,
  output logic [31:0] stat_conflict
`endif
);

  logic                   req0_s;
  logic                   req1_s;
  logic                   pick_any_s;
  logic                   pick_sel_s;
  logic                   gnt_any_s;
  logic [BURST_CNT_W-1:0] burst_inc_s;
  logic                   owner_r;
  logic [BURST_CNT_W-1:0] burst_cnt_r;
  logic                   rd_pend_r;
  logic                   rd_tag_r;

  assign req0_s = req_of(m0_rstrb, m0_wmask);
  assign req1_s = req_of(m1_rstrb, m1_wmask);

  arb_pick #(.MAX_BURST(MAX_BURST)) u_pick (
    .req0      (req0_s),
    .req1      (req1_s),
    .owner     (owner_r),
    .burst_cnt (burst_cnt_r),
    .gnt_any   (pick_any_s),
    .gnt_sel   (pick_sel_s)
  );

  // Reset blocks every grant so nothing reaches the RAM while it is held.
  assign gnt_any_s = pick_any_s & ~reset;
  assign m0_gnt    = gnt_any_s & (pick_sel_s == MASTER_CPU);
  assign m1_gnt    = gnt_any_s & (pick_sel_s == MASTER_AUX);

  assign burst_inc_s = (burst_cnt_r == BURST_CNT_MAX) ? BURST_CNT_MAX : burst_cnt_r + 4'd1;

  // Route the granted master onto the RAM port; idle parks on master 0 with no strobes
  always_comb begin
    mem_addr  = m0_addr;
    mem_wdata = m0_wdata;
    mem_rstrb = 1'b0;
    mem_wmask = 4'b0000;
    if (gnt_any_s) begin
      if (pick_sel_s == MASTER_AUX) begin
        mem_addr  = m1_addr;
        mem_wdata = m1_wdata;
        mem_rstrb = m1_rstrb;
        mem_wmask = m1_wmask;
      end else begin
        mem_addr  = m0_addr;
        mem_wdata = m0_wdata;
        mem_rstrb = m0_rstrb;
        mem_wmask = m0_wmask;
      end
    end else begin
      mem_rstrb = 1'b0;
      mem_wmask = 4'b0000;
    end
  end

  // Ownership and burst tracking
  always_ff @(posedge clk) begin
    if (reset) begin
      owner_r     <= MASTER_CPU;
      burst_cnt_r <= 4'd0;
    end else if (gnt_any_s) begin
      owner_r     <= pick_sel_s;
      burst_cnt_r <= (pick_sel_s == owner_r) ? burst_inc_s : 4'd1;
    end else begin
      owner_r     <= owner_r;
      burst_cnt_r <= 4'd0;
    end
  end

  // Read-return bookkeeping: remember who issued the read granted this cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_pend_r <= 1'b0;
      rd_tag_r  <= MASTER_CPU;
    end else if (gnt_any_s && mem_rstrb) begin
      rd_pend_r <= 1'b1;
      rd_tag_r  <= pick_sel_s;
    end else begin
      rd_pend_r <= 1'b0;
      rd_tag_r  <= rd_tag_r;
    end
  end

  // A read pending across the edge into reset must not surface as rvalid.
  assign m0_rvalid = rd_pend_r & ~reset & (rd_tag_r == MASTER_CPU);
  assign m1_rvalid = rd_pend_r & ~reset & (rd_tag_r == MASTER_AUX);
  assign m0_rdata  = mem_rdata;
  assign m1_rdata  = mem_rdata;

`ifdef ARB_STATS_EN
  // Free-running grant and contention counters, wrapping at 2^32
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_gnt0     <= 32'd0;
      stat_gnt1     <= 32'd0;
      stat_conflict <= 32'd0;
    end else begin
      stat_gnt0     <= stat_gnt0 + {31'd0, m0_gnt};
      stat_gnt1     <= stat_gnt1 + {31'd0, m1_gnt};
      stat_conflict <= stat_conflict + {31'd0, (req0_s & req1_s)};
    end
  end
`endif

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter with a rule-level arbitration/memory model checked every cycle.
module tb_mem_bus_arbiter;

  localparam int MAX_BURST = 4;

  logic        clk;
  logic        reset;
  logic [31:0] m0_addr, m0_wdata, m0_rdata;
  logic        m0_rstrb, m0_gnt, m0_rvalid;
  logic [3:0]  m0_wmask;
  logic [31:0] m1_addr, m1_wdata, m1_rdata;
  logic        m1_rstrb, m1_gnt, m1_rvalid;
  logic [3:0]  m1_wmask;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic        mem_rstrb;
  logic [3:0]  mem_wmask;
`ifdef ARB_STATS_EN
  logic [31:0] stat_gnt0, stat_gnt1, stat_conflict;
`endif

  int nvec = 0;
  int nerr = 0;

  mem_bus_arbiter #(.MAX_BURST(MAX_BURST)) dut (
    .clk(clk), .reset(reset),
    .m0_addr(m0_addr), .m0_rstrb(m0_rstrb), .m0_wdata(m0_wdata), .m0_wmask(m0_wmask),
    .m0_gnt(m0_gnt), .m0_rdata(m0_rdata), .m0_rvalid(m0_rvalid),
    .m1_addr(m1_addr), .m1_rstrb(m1_rstrb), .m1_wdata(m1_wdata), .m1_wmask(m1_wmask),
    .m1_gnt(m1_gnt), .m1_rdata(m1_rdata), .m1_rvalid(m1_rvalid),
    .mem_addr(mem_addr), .mem_rstrb(mem_rstrb), .mem_wdata(mem_wdata), .mem_wmask(mem_wmask),
    .mem_rdata(mem_rdata)
`ifdef ARB_STATS_EN
    , .stat_gnt0(stat_gnt0), .stat_gnt1(stat_gnt1), .stat_conflict(stat_conflict)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Behavioural 64-word RAM with one-cycle read latency (old data on same-cycle write)
  logic        ram_load;
  logic [31:0] ram [0:63];
  always @(posedge clk) begin
    if (ram_load) begin
      for (int i = 0; i < 64; i++) ram[i] <= init_word(i);
    end else begin
      if (mem_rstrb) mem_rdata <= ram[mem_addr[7:2]];
      for (int b = 0; b < 4; b++)
        if (mem_wmask[b]) ram[mem_addr[7:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: who owns the bus, how long its unbroken run is, the pending read, and memory contents
  int          m_owner, m_streak, m_tag, eg;
  bit          m_pend;
  logic [31:0] m_rdata;
  logic [31:0] mm [0:63];

  initial begin : model_cmp
    logic        r0, r1, ers;
    logic [31:0] ea, ed;
    logic [3:0]  ewm;
    for (int i = 0; i < 64; i++) mm[i] = init_word(i);
    m_owner = 0; m_streak = 0; m_pend = 0; m_tag = 0; m_rdata = 32'd0;
    forever begin
      @(negedge clk);
      r0 = m0_rstrb | (|m0_wmask);
      r1 = m1_rstrb | (|m1_wmask);
      if (reset)         eg = -1;
      else if (r0 && r1) eg = (m_streak < MAX_BURST) ? m_owner : 1 - m_owner;
      else if (r0)       eg = 0;
      else if (r1)       eg = 1;
      else               eg = -1;
      ea  = (eg == 1) ? m1_addr  : m0_addr;
      ed  = (eg == 1) ? m1_wdata : m0_wdata;
      ers = (eg == 0) ? m0_rstrb : (eg == 1) ? m1_rstrb : 1'b0;
      ewm = (eg == 0) ? m0_wmask : (eg == 1) ? m1_wmask : 4'b0000;
      check("gnt0", {31'd0, m0_gnt}, {31'd0, eg == 0});
      check("gnt1", {31'd0, m1_gnt}, {31'd0, eg == 1});
      check("mem_addr", mem_addr, ea);
      check("mem_wdata", mem_wdata, ed);
      check("mem_rstrb", {31'd0, mem_rstrb}, {31'd0, ers});
      check("mem_wmask", {28'd0, mem_wmask}, {28'd0, ewm});
      check("rvalid0", {31'd0, m0_rvalid}, {31'd0, m_pend && !reset && m_tag == 0});
      check("rvalid1", {31'd0, m1_rvalid}, {31'd0, m_pend && !reset && m_tag == 1});
      if (m_pend && !reset)
        check("rdata", (m_tag == 0) ? m0_rdata : m1_rdata, m_rdata);
      // advance the model across the coming edge (inputs are stable until after it)
      if (reset) begin
        m_owner = 0; m_streak = 0; m_pend = 0;
      end else begin
        m_pend = 0;
        if (eg >= 0) begin
          if (ers) begin
            m_pend = 1; m_tag = eg; m_rdata = mm[ea[7:2]];
          end
          for (int b = 0; b < 4; b++)
            if (ewm[b]) mm[ea[7:2]][8*b +: 8] = ed[8*b +: 8];
          m_streak = (eg == m_owner) ? m_streak + 1 : 1;
          m_owner  = eg;
        end else begin
          m_streak = 0;
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic settle;
    #2;
  endtask

  task automatic set_m0(input logic rs, input logic [3:0] wm, input logic [31:0] a, input logic [31:0] d);
    m0_rstrb = rs; m0_wmask = wm; m0_addr = a; m0_wdata = d;
  endtask

  task automatic set_m1(input logic rs, input logic [3:0] wm, input logic [31:0] a, input logic [31:0] d);
    m1_rstrb = rs; m1_wmask = wm; m1_addr = a; m1_wdata = d;
  endtask

  task automatic idle;
    set_m0(1'b0, 4'b0000, 32'd0, 32'd0);
    set_m1(1'b0, 4'b0000, 32'd0, 32'd0);
  endtask

  logic [9:0] exp_seq;

  initial begin
    reset = 1'b1; ram_load = 1'b1; mem_rdata = 32'd0;
    idle();
    tick(); ram_load = 1'b0;
    // requests are ignored while reset is held
    set_m0(1'b1, 4'b1111, 32'h10, 32'h1);
    settle(); check("rst_gnt0", {31'd0, m0_gnt}, 32'd0);
    check("rst_rstrb", {31'd0, mem_rstrb}, 32'd0);
    check("rst_wmask", {28'd0, mem_wmask}, 32'd0);
    tick(); reset = 1'b0; idle(); tick();

    // single master write then read-back
    set_m0(1'b0, 4'b1111, 32'h10, 32'hDEADBEEF);
    settle(); check("wr_gnt0", {31'd0, m0_gnt}, 32'd1); check("wr_gnt1", {31'd0, m1_gnt}, 32'd0);
    tick(); set_m0(1'b1, 4'b0000, 32'h10, 32'd0);
    settle(); check("rd_gnt0", {31'd0, m0_gnt}, 32'd1);
    tick(); idle();
    settle(); check("rd_rvalid0", {31'd0, m0_rvalid}, 32'd1);
    check("rd_rdata0", m0_rdata, 32'hDEADBEEF); check("rd_rvalid1", {31'd0, m1_rvalid}, 32'd0);
    tick();

    // m1 read+partial write in one request returns the old word
    set_m1(1'b1, 4'b0011, 32'h20, 32'hCAFE1234);
    settle(); check("rw_gnt1", {31'd0, m1_gnt}, 32'd1);
    tick(); set_m1(1'b1, 4'b0000, 32'h20, 32'd0);
    settle(); check("rw_old", m1_rdata, 32'hA5A50008);
    tick(); idle();
    settle(); check("rw_new", m1_rdata, 32'hA5A51234); check("rw_rvalid1", {31'd0, m1_rvalid}, 32'd1);
    tick();

    // contention straight out of reset
    reset = 1'b1; tick(); tick(); reset = 1'b0;
    set_m0(1'b1, 4'b0000, 32'h0, 32'd0); set_m1(1'b1, 4'b0000, 32'h4, 32'd0);
    exp_seq = 10'b00_1111_0000;
    for (int i = 0; i < 10; i++) begin
      settle();
      check($sformatf("cont_gnt1_%0d", i), {31'd0, m1_gnt}, {31'd0, exp_seq[i]});
      check($sformatf("cont_gnt0_%0d", i), {31'd0, m0_gnt}, {31'd0, ~exp_seq[i]});
      tick();
    end
    idle();
`ifdef ARB_STATS_EN
    check("stat_conflict", stat_conflict, 32'd10);
    check("stat_gnt0", stat_gnt0, 32'd6);
    check("stat_gnt1", stat_gnt1, 32'd4);
`endif
    tick();

    // interleaved single reads
    set_m0(1'b1, 4'b0000, 32'h0, 32'd0);
    settle(); check("il_gnt0", {31'd0, m0_gnt}, 32'd1);
    tick(); set_m0(1'b0, 4'b0000, 32'd0, 32'd0); set_m1(1'b1, 4'b0000, 32'h4, 32'd0);
    settle(); check("il_rv0", {31'd0, m0_rvalid}, 32'd1); check("il_d0", m0_rdata, 32'hA5A50000);
    check("il_rv1_early", {31'd0, m1_rvalid}, 32'd0); check("il_gnt1", {31'd0, m1_gnt}, 32'd1);
    tick(); idle();
    settle(); check("il_rv1", {31'd0, m1_rvalid}, 32'd1); check("il_d1", m1_rdata, 32'hA5A50001);
    check("il_rv0_late", {31'd0, m0_rvalid}, 32'd0);
    tick();

    // idle gap keeps the owner but restarts its burst
    set_m1(1'b1, 4'b0000, 32'h8, 32'd0); tick(); tick();
    idle(); tick();
    set_m0(1'b1, 4'b0000, 32'h0, 32'd0); set_m1(1'b1, 4'b0000, 32'hC, 32'd0);
    settle(); check("gap_gnt1", {31'd0, m1_gnt}, 32'd1); check("gap_gnt0", {31'd0, m0_gnt}, 32'd0);
    tick(); idle(); tick();

    // reset right after a granted read kills its return
    set_m1(1'b1, 4'b0000, 32'h4, 32'd0);
    settle(); check("mr_gnt1", {31'd0, m1_gnt}, 32'd1);
    tick(); idle(); reset = 1'b1;
    settle(); check("mr_rv1_a", {31'd0, m1_rvalid}, 32'd0);
    tick();
    set_m0(1'b1, 4'b0000, 32'h0, 32'd0); set_m1(1'b1, 4'b0000, 32'h4, 32'd0);
    settle(); check("mr_rv1_b", {31'd0, m1_rvalid}, 32'd0);
    tick(); reset = 1'b0;
    settle(); check("mr_gnt0", {31'd0, m0_gnt}, 32'd1); check("mr_gnt1b", {31'd0, m1_gnt}, 32'd0);
    tick(); idle(); tick(); tick();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
